// File: rtl/temp_period_meter.sv
// Period/duty meter for a ring-oscillator temperature sensor: synchronises the comparator output,
// counts cycles per period and reports a windowed average with a saturation flag.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | measurement disabled; cnt/acc/win/povf held at zero
// ST_ARM   | waiting for the first edge; the partial period before it is discarded
// ST_COUNT | counting periods; each edge closes one period and feeds the window
module temp_period_meter #(
    parameter int CNT_W       = 12,
    parameter int AVG_LOG2    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             analog_out,
    output logic [CNT_W-1:0] b,
    output logic             valid,
    output logic             ovf,
    output logic             busy
);
    localparam int ACC_W = CNT_W + AVG_LOG2;
    // A zero-width window counter is not legal; with no averaging it stays at 0 and every edge ends a window.
    localparam int WIN_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'((1 << AVG_LOG2) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_START = (MODE == 1) ? CNT_W'(1) : '0;

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_COUNT} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [ACC_W-1:0]       r_acc;
    logic [WIN_W-1:0]       r_win;
    logic                   r_povf;
    logic [CNT_W-1:0]       r_b;
    logic                   r_valid;
    logic                   r_ovf;

    logic                   w_s;
    logic                   w_edge;
    logic                   w_win_done;
    logic [ACC_W-1:0]       w_sum;

    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_s & ~r_s_d;
    assign w_win_done = (r_win == WIN_LAST);
    assign w_sum      = r_acc + ACC_W'(r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], analog_out};
            r_s_d  <= w_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_win   <= '0;
            r_povf  <= 1'b0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            // Dropping enable wins over any edge in flight, including a window-completing one.
            if (!enable) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_acc   <= '0;
                r_win   <= '0;
                r_povf  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_win   <= '0;
                        r_povf  <= 1'b0;
                    end
                    ST_ARM: begin
                        if (w_edge) begin
                            r_state <= ST_COUNT;
                            r_cnt   <= CNT_START;
                        end
                    end
                    ST_COUNT: begin
                        if (w_edge) begin
                            r_cnt <= CNT_START;
                            if (w_win_done) begin
                                r_b     <= CNT_W'(w_sum >> AVG_LOG2);
                                r_ovf   <= r_povf | (r_cnt == CNT_MAX);
                                r_valid <= 1'b1;
                                r_acc   <= '0;
                                r_win   <= '0;
                                r_povf  <= 1'b0;
                            end else begin
                                r_acc <= w_sum;
                                r_win <= r_win + WIN_W'(1);
                            end
                        end else if ((MODE == 1) || !w_s) begin
                            if (r_cnt != CNT_MAX) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                                if (r_cnt == CNT_MAX - CNT_W'(1))
                                    r_povf <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign b     = r_b;
    assign valid = r_valid;
    assign ovf   = r_ovf;
    assign busy  = (r_state != ST_IDLE);
endmodule

// File: doc/temp_period_meter.md
TEMP_PERIOD_METER -- requirements
Module: temp_period_meter

Interface
REQ-001 Parameter CNT_W, default 12: width of the per-period counter and of output b.
REQ-002 Parameter AVG_LOG2, default 2: results are averaged over 2^AVG_LOG2 periods; 0 means no averaging.
REQ-003 Parameter SYNC_STAGES, default 2 (minimum 2): number of synchroniser flops on analog_out.
REQ-004 Parameter MODE, default 0: 0 = count low (charging) cycles only; 1 = count full rising-to-rising period.
REQ-005 clk  input  1  sole clock; all state on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  measurement enable, synchronous to clk.
REQ-008 analog_out  input  1  comparator output from the analog core, asynchronous to clk.
REQ-009 b  output  CNT_W  latest averaged count.
REQ-010 valid  output  1  one-cycle pulse; b updated in the same cycle.
REQ-011 ovf  output  1  saturation flag for the window that produced the current b.
REQ-012 busy  output  1  high in ARM or COUNT state.

Function
REQ-013 analog_out SHALL pass through SYNC_STAGES flops; s = last stage, s_d = s delayed one cycle; edge = s & ~s_d.
REQ-014 FSM states SHALL be IDLE, ARM and COUNT.
REQ-015 IDLE: enable=1 -> ARM. In IDLE, cnt, acc and win SHALL be held at 0.
REQ-016 ARM: the first edge -> COUNT. The partial period before it SHALL be discarded and cnt SHALL be loaded with the MODE start value (REQ-018).
REQ-017 Any state with enable=0 -> IDLE on the next clock. cnt, acc, win SHALL clear; b and ovf SHALL hold; valid SHALL be 0.
REQ-018 COUNT, edge cycle: the period value is cnt. cnt SHALL reload with 0 (MODE=0) or 1 (MODE=1).
REQ-019 COUNT, non-edge cycle: cnt SHALL increment when MODE=1, or when MODE=0 and s=0; otherwise it holds.
REQ-020 cnt SHALL saturate at 2^CNT_W-1, never wrap. Reaching saturation SHALL set a window-sticky flag povf.
REQ-021 On each COUNT edge, acc (width CNT_W+AVG_LOG2) SHALL add the period value and win (width AVG_LOG2) SHALL increment modulo 2^AVG_LOG2.
REQ-022 When the edge completes a window (win wraps to 0, or AVG_LOG2=0), the outputs SHALL update on that same clock edge:
  - b <= (acc + period) >> AVG_LOG2, truncated;
  - ovf <= povf | (period saturated);
  - valid <= 1 for exactly one cycle.
  acc and povf SHALL clear on that edge.
REQ-023 Latency: valid SHALL rise one clk after the edge term is true. This is SYNC_STAGES+1 cycles after analog_out rises, given setup is met.
REQ-024 Back-to-back edges, including period value 0 or 1, SHALL each be processed. valid MAY assert on consecutive cycles.
REQ-025 If enable falls on the same cycle as a window-completing edge, the enable drop SHALL take priority: no valid and no b update.
REQ-026 While s remains high for multiple cycles, cnt SHALL hold (MODE=0) and no further edges SHALL be generated.

Reset
REQ-027 rst_n=0 SHALL immediately force the following, regardless of clk:
  - state=IDLE;
  - b=0, valid=0, ovf=0;
  - cnt, acc, win, povf = 0;
  - all synchroniser flops and s_d = 0.
REQ-028 After rst_n rises, the first edge SHALL be treated per ARM. A reset mid-window SHALL discard all partial data.

Verification
REQ-029 CNT_W=8, AVG_LOG2=0, MODE=0, enable=1; analog_out repeating 10 cycles low / 5 high -> first edge discarded, then valid pulses every 15 cycles with b=10, ovf=0.
REQ-030 Same stimulus with MODE=1 -> b=15 on every valid.
REQ-031 AVG_LOG2=2, MODE=0; successive low times 8, 9, 10, 11 -> a single valid after the fourth period with b=9 (38>>2); no valid earlier.
REQ-032 CNT_W=8, AVG_LOG2=0; low time 300 cycles -> b=255, ovf=1. The next period of 10 low cycles -> b=10, ovf=0.
REQ-033 enable dropped after 2 of 4 periods, then re-raised -> busy falls, no valid, b holds. The next valid requires a discarded first edge plus 4 full periods.
REQ-034 rst_n pulsed low asynchronously mid-count -> all outputs 0 within the same cycle, with no valid following the first post-reset edge.
